pipelined_write_assembler: RTL and testbench
============================================

# pipelined_write_assembler

Receives a pipelined write stream (one command cycle followed by 1..MAX_WR_CYCLES data cycles with IDLE bubbles allowed) and reassembles it into a single wide write on a valid/ready output. It generalises the fixed 4×8-bit pipelined write to parametrised width and depth. It generates per-cycle and per-transaction write-done pulses according to the write type, and flags protocol violations. It sits at the sink end of a pipelined write link, in front of the target register/memory write port.

## Interface
- WR_WIDTH, 8, data bits per data cycle (≥1)
- MAX_WR_CYCLES, 4, maximum data cycles per write (≥2)
- CNT_W, 16, width of the completed-write counter
- NCW (derived), clog2(MAX_WR_CYCLES), width of num_cycles fields
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_val  in  1  command cycle; start of a new write
- cmd_num_cycles  in  NCW  data cycles in this write; 0 means MAX_WR_CYCLES
- cmd_write_type  in  2  0 STD, 1 MULTI_WDONE, 2 SINGLE_WDONE, 3 reserved
- dat_cycle_type  in  2  0 IDLE, 1 VALID, 2 DONE, 3 reserved
- dat  in  WR_WIDTH  data payload of a VALID/DONE cycle
- out_vld  out  1  assembled write available
- out_rdy  in  1  consumer accepts the assembled write
- out_dat  out  MAX_WR_CYCLES*WR_WIDTH  data cycle i at bits [i*WR_WIDTH +: WR_WIDTH]; unused slots zero
- out_num_cycles  out  NCW+1  actual data cycle count (1..MAX_WR_CYCLES)
- out_write_type  out  2  write type of the held write
- wdone_cycle  out  1  per-data-cycle done pulse (MULTI_WDONE)
- wdone_xact  out  1  per-transaction done pulse (SINGLE_WDONE)
- err  out  1  single-cycle protocol error pulse
- err_code  out  3  1 ORPHAN, 2 CMD_BUSY, 3 SHORT, 4 LONG, 5 OVERFLOW, 6 BAD_TYPE; 0 when err=0
- xact_cnt  out  CNT_W  count of writes delivered on output (wraps)

## Operation
- States: IDLE, COLLECT. Output holding register is independent of state.
- IDLE: cmd_val → latch target N (0 → MAX_WR_CYCLES) and write type; type 3 is latched as STD with err BAD_TYPE. Clear slot count and assembly buffer; go to COLLECT. Data inputs are ignored in the cmd_val cycle.
- IDLE, no cmd_val, dat_cycle_type VALID/DONE → err ORPHAN; data is discarded.
- COLLECT, dat_cycle_type IDLE → bubble, no effect. Type 3 → err BAD_TYPE, cycle ignored.
- COLLECT, VALID with count < N-1 → store dat in slot count and increment count.
- COLLECT, DONE with count == N-1 → store dat and complete the write; go to IDLE.
- COLLECT, DONE with count < N-1 → err SHORT; drop the write; go to IDLE.
- COLLECT, VALID with count == N-1 → err LONG; drop the write; go to IDLE.
- COLLECT, cmd_val → err CMD_BUSY; abort the current write and restart COLLECT with the new command.
- Completion: load the holding register if it is empty or being drained this cycle (out_vld && out_rdy). Otherwise raise err OVERFLOW, drop the new write and keep the held one unchanged.
- MULTI_WDONE: wdone_cycle pulses once per stored data cycle, including cycles of writes later dropped.
- SINGLE_WDONE: wdone_xact pulses once per output handshake of a held write with out_write_type SINGLE_WDONE.
- STD: no wdone pulses.
- Only one error per cycle. Priority: CMD_BUSY > BAD_TYPE > OVERFLOW > SHORT/LONG/ORPHAN.
- xact_cnt increments on each out_vld && out_rdy and wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, synchronous-deassert use): state IDLE. out_vld, out_dat, out_num_cycles, out_write_type, wdone_cycle, wdone_xact, err, err_code and xact_cnt are all 0.
- Reset mid-write discards all partial and held data.
- Completing DONE at cycle t → out_vld=1 at t+1. Minimum write latency is cmd at t, DONE at t+N, out_vld at t+N+1.
- out_vld stays high, with out_* stable, until the handshake cycle. It deasserts the next cycle unless reloaded in that same cycle.
- Back-to-back: a new cmd_val is legal in the cycle after DONE.
- wdone_cycle: registered, asserted the cycle after the data cycle is stored.
- wdone_xact: asserted the cycle after the handshake.
- err and err_code: registered, asserted the cycle after the offending input, one-cycle pulse.
- Completion and handshake in the same cycle → output reloaded, out_vld remains 1, no OVERFLOW.

## Test plan
- Defaults: cmd N=0 STD, then VALID 0x11, IDLE, VALID 0x22, VALID 0x33, DONE 0x44 → one cycle later out_vld=1, out_dat=0x44332211, out_num_cycles=4; no wdone pulses; after handshake xact_cnt=1.
- MULTI_WDONE N=2 with data 0xA5, DONE 0x5A → two wdone_cycle pulses; out_dat=0x00005AA5, out_num_cycles=2.
- SINGLE_WDONE N=1 with out_rdy=0 for 5 cycles, then out_rdy=1 → out_vld held 5 cycles with stable data; one wdone_xact pulse the cycle after the handshake.
- Error set: DONE after one VALID with N=3 → err_code 3. VALID at count 2 with N=3 → code 4. Data in IDLE → code 1. cmd during COLLECT → code 2, followed by a correct completion of the new write. cmd_write_type=3 → code 6 and the write is treated as STD.
- Overflow: hold out_rdy=0 and complete two writes → err_code 5 on the second; out_dat keeps the first write. Then complete a write in the same cycle as a handshake → reload with no error.
- Assert rst_n low mid-COLLECT and while out_vld=1 → all outputs 0 immediately. Next write assembles correctly with no stale slots, and xact_cnt=0 before the first handshake.

Source files
------------

// File: rtl/pipelined_write_assembler.sv
// Reassembles a pipelined write stream (command cycle + 1..MAX_WR_CYCLES data cycles)
// into one wide write on a valid/ready output, with write-done pulses and error reporting.
module pipelined_write_assembler #(
  parameter int unsigned WR_WIDTH      = 8,
  parameter int unsigned MAX_WR_CYCLES = 4,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned NCW          = $clog2(MAX_WR_CYCLES),
  localparam int unsigned OUT_W        = MAX_WR_CYCLES * WR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_val,
  input  logic [NCW-1:0]   cmd_num_cycles,
  input  logic [1:0]       cmd_write_type,
  input  logic [1:0]       dat_cycle_type,
  input  logic [WR_WIDTH-1:0] dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [OUT_W-1:0] out_dat,
  output logic [NCW:0]     out_num_cycles,
  output logic [1:0]       out_write_type,
  output logic             wdone_cycle,
  output logic             wdone_xact,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] xact_cnt
);

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_COLLECT = 1'b1;

  localparam logic [1:0] WT_STD    = 2'd0;
  localparam logic [1:0] WT_MULTI  = 2'd1;
  localparam logic [1:0] WT_SINGLE = 2'd2;
  localparam logic [1:0] WT_RSVD   = 2'd3;

  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_RSVD  = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ORPHAN   = 3'd1;
  localparam logic [2:0] ERR_CMD_BUSY = 3'd2;
  localparam logic [2:0] ERR_SHORT    = 3'd3;
  localparam logic [2:0] ERR_LONG     = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW = 3'd5;
  localparam logic [2:0] ERR_BAD_TYPE = 3'd6;

  localparam logic [NCW:0] MAX_N = (NCW+1)'(MAX_WR_CYCLES);

  logic             state, state_nxt;
  logic [NCW:0]     tgt_n, tgt_nxt;
  logic [1:0]       wtype, wtype_nxt;
  logic [NCW:0]     cnt, cnt_nxt;
  logic [OUT_W-1:0] asm_buf, asm_nxt, asm_ins;
  logic [NCW:0]     cmd_tgt;
  logic             cnt_last;
  logic             drain;
  logic             stored;
  logic             complete;
  logic             out_vld_nxt;
  logic [OUT_W-1:0] out_dat_nxt;
  logic [NCW:0]     out_nc_nxt;
  logic [1:0]       out_wt_nxt;
  logic [2:0]       err_code_nxt;

  assign drain    = out_vld && out_rdy;
  assign cnt_last = (cnt == tgt_n - (NCW+1)'(1));

  // Target length of an incoming command; 0 (and anything out of range) means full depth
  always_comb begin
    cmd_tgt = (NCW+1)'(cmd_num_cycles);
    if ((cmd_num_cycles == '0) || ((NCW+1)'(cmd_num_cycles) > MAX_N)) begin
      cmd_tgt = MAX_N;
    end
  end

  // Assembly buffer with the current data cycle dropped into slot cnt
  always_comb begin
    asm_ins = asm_buf;
    for (int unsigned i = 0; i < MAX_WR_CYCLES; i++) begin
      if (cnt == (NCW+1)'(i)) begin
        asm_ins[i*WR_WIDTH +: WR_WIDTH] = dat;
      end
    end
  end

  // Next-state, assembly and error decode
  always_comb begin
    state_nxt    = state;
    tgt_nxt      = tgt_n;
    wtype_nxt    = wtype;
    cnt_nxt      = cnt;
    asm_nxt      = asm_buf;
    out_vld_nxt  = out_vld;
    out_dat_nxt  = out_dat;
    out_nc_nxt   = out_num_cycles;
    out_wt_nxt   = out_write_type;
    err_code_nxt = ERR_NONE;
    stored       = 1'b0;
    complete     = 1'b0;

    if (cmd_val) begin
      // A command always (re)starts collection; an in-flight write is abandoned
      state_nxt = S_COLLECT;
      tgt_nxt   = cmd_tgt;
      wtype_nxt = (cmd_write_type == WT_RSVD) ? WT_STD : cmd_write_type;
      cnt_nxt   = '0;
      asm_nxt   = '0;
      if (state == S_COLLECT) begin
        err_code_nxt = ERR_CMD_BUSY;
      end else if (cmd_write_type == WT_RSVD) begin
        err_code_nxt = ERR_BAD_TYPE;
      end
    end else if (state == S_IDLE) begin
      if ((dat_cycle_type == CT_VALID) || (dat_cycle_type == CT_DONE)) begin
        err_code_nxt = ERR_ORPHAN;
      end
    end else begin
      case (dat_cycle_type)
        CT_VALID: begin
          if (!cnt_last) begin
            asm_nxt = asm_ins;
            cnt_nxt = cnt + (NCW+1)'(1);
            stored  = 1'b1;
          end else begin
            err_code_nxt = ERR_LONG;
            state_nxt    = S_IDLE;
          end
        end
        CT_DONE: begin
          if (cnt_last) begin
            stored   = 1'b1;
            complete = 1'b1;
          end else begin
            err_code_nxt = ERR_SHORT;
          end
          state_nxt = S_IDLE;
        end
        CT_RSVD: err_code_nxt = ERR_BAD_TYPE;
        default: ;
      endcase
    end

    // Holding register: reload when empty or draining this cycle, otherwise drop the new write
    if (complete) begin
      if (!out_vld || drain) begin
        out_vld_nxt = 1'b1;
        out_dat_nxt = asm_ins;
        out_nc_nxt  = tgt_n;
        out_wt_nxt  = wtype;
      end else begin
        err_code_nxt = ERR_OVERFLOW;
      end
    end else if (drain) begin
      out_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      tgt_n          <= '0;
      wtype          <= WT_STD;
      cnt            <= '0;
      asm_buf        <= '0;
      out_vld        <= 1'b0;
      out_dat        <= '0;
      out_num_cycles <= '0;
      out_write_type <= WT_STD;
      wdone_cycle    <= 1'b0;
      wdone_xact     <= 1'b0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
      xact_cnt       <= '0;
    end else begin
      state          <= state_nxt;
      tgt_n          <= tgt_nxt;
      wtype          <= wtype_nxt;
      cnt            <= cnt_nxt;
      asm_buf        <= asm_nxt;
      out_vld        <= out_vld_nxt;
      out_dat        <= out_dat_nxt;
      out_num_cycles <= out_nc_nxt;
      out_write_type <= out_wt_nxt;
      wdone_cycle    <= stored && (wtype == WT_MULTI);
      wdone_xact     <= drain && (out_write_type == WT_SINGLE);
      err            <= (err_code_nxt != ERR_NONE);
      err_code       <= err_code_nxt;
      xact_cnt       <= xact_cnt + CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_pipelined_write_assembler.sv
// Directed and randomized bench for pipelined_write_assembler, checked every cycle
// against a queue-based transaction model.
module tb_pipelined_write_assembler;

  localparam int unsigned W     = 8;
  localparam int unsigned MAXC  = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned NCW   = $clog2(MAXC);
  localparam int unsigned OUT_W = MAXC * W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_val;
  logic [NCW-1:0]   cmd_num_cycles;
  logic [1:0]       cmd_write_type;
  logic [1:0]       dat_cycle_type;
  logic [W-1:0]     dat;
  logic             out_vld;
  logic             out_rdy;
  logic [OUT_W-1:0] out_dat;
  logic [NCW:0]     out_num_cycles;
  logic [1:0]       out_write_type;
  logic             wdone_cycle;
  logic             wdone_xact;
  logic             err;
  logic [2:0]       err_code;
  logic [CW-1:0]    xact_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_write_assembler #(.WR_WIDTH(W), .MAX_WR_CYCLES(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .cmd_num_cycles(cmd_num_cycles),
    .cmd_write_type(cmd_write_type), .dat_cycle_type(dat_cycle_type), .dat(dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_num_cycles(out_num_cycles),
    .out_write_type(out_write_type), .wdone_cycle(wdone_cycle), .wdone_xact(wdone_xact),
    .err(err), .err_code(err_code), .xact_cnt(xact_cnt)
  );

  always #5 clk = ~clk;

  // Transaction-level reference model
  bit           m_busy;
  int           m_n;
  int           m_type;
  logic [W-1:0] m_q[$];
  bit           m_vld;
  logic [OUT_W-1:0] m_dat;
  int           m_nc;
  int           m_wt;
  bit           m_wc, m_wx, m_err;
  int           m_code;
  logic [CW-1:0] m_xcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_n = 0; m_type = 0; m_q.delete();
    m_vld = 0; m_dat = '0; m_nc = 0; m_wt = 0;
    m_wc = 0; m_wx = 0; m_err = 0; m_code = 0; m_xcnt = '0;
  endtask

  task automatic model_step();
    bit drain = m_vld && out_rdy;
    bit done  = 0;
    int code  = 0;
    m_wc = 0;
    m_wx = drain && (m_wt == 2);
    if (cmd_val) begin
      if (m_busy) code = 2;
      else if (cmd_write_type == 3) code = 6;
      m_busy = 1;
      m_n    = (cmd_num_cycles == 0) ? MAXC : int'(cmd_num_cycles);
      m_type = (cmd_write_type == 3) ? 0 : int'(cmd_write_type);
      m_q.delete();
    end else if (!m_busy) begin
      if (dat_cycle_type == 1 || dat_cycle_type == 2) code = 1;
    end else begin
      case (dat_cycle_type)
        2'd1: if (m_q.size() < m_n - 1) begin m_q.push_back(dat); m_wc = (m_type == 1); end
              else begin code = 4; m_busy = 0; end
        2'd2: if (m_q.size() == m_n - 1) begin
                m_q.push_back(dat); m_wc = (m_type == 1); done = 1; m_busy = 0;
              end else begin code = 3; m_busy = 0; end
        2'd3: code = 6;
        default: ;
      endcase
    end
    if (done) begin
      if (!m_vld || drain) begin
        m_vld = 1; m_dat = '0;
        foreach (m_q[i]) m_dat[i*W +: W] = m_q[i];
        m_nc = m_n; m_wt = m_type;
      end else code = 5;
    end else if (drain) m_vld = 0;
    if (drain) m_xcnt = m_xcnt + 1'b1;
    m_err  = (code != 0);
    m_code = code;
  endtask

  task automatic compare_all(input string p);
    check({p, ".out_vld"}, 64'(out_vld), 64'(m_vld));
    check({p, ".out_dat"}, 64'(out_dat), 64'(m_dat));
    check({p, ".out_num_cycles"}, 64'(out_num_cycles), 64'(m_nc));
    check({p, ".out_write_type"}, 64'(out_write_type), 64'(m_wt));
    check({p, ".wdone_cycle"}, 64'(wdone_cycle), 64'(m_wc));
    check({p, ".wdone_xact"}, 64'(wdone_xact), 64'(m_wx));
    check({p, ".err"}, 64'(err), 64'(m_err));
    check({p, ".err_code"}, 64'(err_code), 64'(m_code));
    check({p, ".xact_cnt"}, 64'(xact_cnt), 64'(m_xcnt));
  endtask

  task automatic tick(input logic cv, input int nc, input int wt, input int dct,
                      input logic [W-1:0] d, input logic rdy);
    @(negedge clk);
    cmd_val        = cv;
    cmd_num_cycles = NCW'(nc);
    cmd_write_type = 2'(wt);
    dat_cycle_type = 2'(dct);
    dat            = d;
    out_rdy        = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear immediately
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    cmd_val = 0; dat_cycle_type = 0; out_rdy = 0;
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; cmd_val = 0; cmd_num_cycles = '0; cmd_write_type = '0;
    dat_cycle_type = '0; dat = '0; out_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Default 4-cycle STD write with a bubble
    tick(1, 0, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 1, 8'h11, 0);
    tick(0, 0, 0, 0, 8'h00, 0);
    tick(0, 0, 0, 1, 8'h22, 0);
    tick(0, 0, 0, 1, 8'h33, 0);
    tick(0, 0, 0, 2, 8'h44, 0);
    check("def.vld", 64'(out_vld), 64'd1);
    check("def.dat", 64'(out_dat), 64'h44332211);
    check("def.nc", 64'(out_num_cycles), 64'd4);
    tick(0, 0, 0, 0, 8'h00, 1);
    check("def.xcnt", 64'(xact_cnt), 64'd1);

    // MULTI_WDONE, N=2
    pulses = 0;
    tick(1, 2, 1, 0, 8'h00, 0); pulses += int'(wdone_cycle);
    tick(0, 0, 0, 1, 8'hA5, 0); pulses += int'(wdone_cycle);
    tick(0, 0, 0, 2, 8'h5A, 0); pulses += int'(wdone_cycle);
    check("multi.pulses", 64'(pulses), 64'd2);
    check("multi.dat", 64'(out_dat), 64'h00005AA5);
    check("multi.nc", 64'(out_num_cycles), 64'd2);
    tick(0, 0, 0, 0, 8'h00, 1);

    // SINGLE_WDONE, N=1, consumer stalls 5 cycles
    tick(1, 1, 2, 0, 8'h00, 0);
    tick(0, 0, 0, 2, 8'h77, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 8'h00, 0);
      check("single.hold_vld", 64'(out_vld), 64'd1);
      check("single.hold_dat", 64'(out_dat), 64'h77);
    end
    tick(0, 0, 0, 0, 8'h00, 1);
    check("single.wx", 64'(wdone_xact), 64'd1);
    tick(0, 0, 0, 0, 8'h00, 0);
    check("single.wx_off", 64'(wdone_xact), 64'd0);

    // Protocol errors
    tick(1, 3, 0, 0, 8'h00, 0); tick(0, 0, 0, 1, 8'h01, 0); tick(0, 0, 0, 2, 8'h02, 0);
    check("err.short", 64'(err_code), 64'd3);
    tick(1, 3, 0, 0, 8'h00, 0); tick(0, 0, 0, 1, 8'h01, 0); tick(0, 0, 0, 1, 8'h02, 0);
    tick(0, 0, 0, 1, 8'h03, 0);
    check("err.long", 64'(err_code), 64'd4);
    tick(0, 0, 0, 1, 8'h04, 0);
    check("err.orphan", 64'(err_code), 64'd1);
    tick(1, 2, 0, 0, 8'h00, 0); tick(0, 0, 0, 1, 8'h05, 0);
    tick(1, 1, 1, 0, 8'h00, 0);
    check("err.busy", 64'(err_code), 64'd2);
    tick(0, 0, 0, 2, 8'h99, 0);
    check("err.busy_done", 64'(out_dat), 64'h99);
    tick(0, 0, 0, 0, 8'h00, 1);
    tick(1, 1, 3, 0, 8'h00, 0);
    check("err.badtype", 64'(err_code), 64'd6);
    tick(0, 0, 0, 2, 8'h3C, 0);
    check("err.badtype_std", 64'(out_write_type), 64'd0);
    tick(0, 0, 0, 0, 8'h00, 1);

    // Overflow, then completion coincident with handshake
    tick(1, 1, 0, 0, 8'h00, 0); tick(0, 0, 0, 2, 8'hAA, 0);
    tick(1, 1, 0, 0, 8'h00, 0); tick(0, 0, 0, 2, 8'hBB, 0);
    check("ovf.code", 64'(err_code), 64'd5);
    check("ovf.keep", 64'(out_dat), 64'hAA);
    tick(1, 1, 0, 0, 8'h00, 0); tick(0, 0, 0, 2, 8'hCC, 1);
    check("reload.err", 64'(err), 64'd0);
    check("reload.vld", 64'(out_vld), 64'd1);
    check("reload.dat", 64'(out_dat), 64'hCC);
    tick(0, 0, 0, 0, 8'h00, 1);

    // Reset mid-COLLECT and with a held write
    tick(1, 0, 0, 0, 8'h00, 0); tick(0, 0, 0, 1, 8'hEE, 0);
    do_reset("rst_collect");
    tick(1, 1, 0, 0, 8'h00, 0); tick(0, 0, 0, 2, 8'h55, 0);
    do_reset("rst_held");
    tick(1, 2, 0, 0, 8'h00, 0); tick(0, 0, 0, 1, 8'h66, 0); tick(0, 0, 0, 2, 8'h77, 0);
    check("post_rst.dat", 64'(out_dat), 64'h7766);
    check("post_rst.xcnt", 64'(xact_cnt), 64'd0);
    tick(0, 0, 0, 0, 8'h00, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      int dct;
      r = int'($urandom_range(0, 99));
      dct = (r < 25) ? 0 : (r < 70) ? 1 : (r < 95) ? 2 : 3;
      tick(($urandom_range(0, 9) == 0), int'($urandom_range(0, MAXC - 1)),
           int'($urandom_range(0, 3)), dct, W'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
